// File: rtl/mem_port_arbiter.sv
// Arbiter between the fetch port and the data port for one single-ported,
// fixed-latency memory. Data has priority, and a starvation counter guarantees fetch progress.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_whb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_whb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int unsigned LAT_W = 5;
    localparam int unsigned STV_W = 4;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY + 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             kill_q, kill_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [2:0]       mem_whb_q, mem_whb_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic             d_rvalid_q, d_rvalid_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             if_gnt_c, d_gnt_c;

    // Next-state: arbitration in IDLE, latency count and response capture while busy
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        kill_d      = kill_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_whb_d   = mem_whb_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        if_gnt_c    = 1'b0;
        d_gnt_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rst) begin
                    if (if_req && !if_kill && (!d_req || starve_q == STV_MAX)) begin
                        if_gnt_c = 1'b1;
                    end else if (d_req) begin
                        d_gnt_c = 1'b1;
                    end
                end
                if (if_gnt_c) begin
                    state_d    = S_BUSY_I;
                    lat_d      = LAT_W'(1);
                    kill_d     = 1'b0;
                    starve_d   = '0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    mem_whb_d  = 3'b010;
                end
                if (d_gnt_c) begin
                    state_d     = S_BUSY_D;
                    lat_d       = LAT_W'(1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_whb_d   = d_whb;
                    if (if_req && starve_q != STV_MAX) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (state_q == S_BUSY_I && if_kill) begin
                    kill_d = 1'b1;
                end
                if (lat_q == LAT_LAST) begin
                    // capture cycle: a kill arriving now still suppresses the response
                    state_d = S_IDLE;
                    lat_d   = '0;
                    kill_d  = 1'b0;
                    if (state_q == S_BUSY_I) begin
                        if_rvalid_d = !(kill_q || if_kill);
                        if (!(kill_q || if_kill)) begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_we_q ? 32'd0 : mem_rdata;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                lat_d   = '0;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            kill_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_whb_q   <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            kill_q      <= kill_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_whb_q   <= mem_whb_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign d_gnt     = d_gnt_c;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_whb   = mem_whb_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory strobes and responses cycle by cycle, including kills and mid-access resets.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int unsigned L  = 2;
    localparam int unsigned SL = 4;
    localparam int NCYC = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_whb;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_whb;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_whb(d_whb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_whb(mem_whb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    // Reference model: one outstanding access described by its grant cycle
    bit          pend, p_fetch, p_killed, p_store;
    int          t_gnt;
    logic [31:0] p_addr, p_data;
    int          starve;
    logic [31:0] last_addr, last_wdata;
    logic        last_we;
    logic [2:0]  last_whb;
    bit          rst_prev, if_pend, d_pend;
    bit          exp_en, exp_busy, exp_iv, exp_dv, exp_ig, exp_dg;
    int          mode;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_whb = '0; mem_rdata = '0;
        rst_prev = 1'b1; if_pend = 1'b0; d_pend = 1'b0; pend = 1'b0; starve = 0; t_gnt = 0;
        p_fetch = 1'b0; p_killed = 1'b0; p_store = 1'b0; p_addr = '0; p_data = '0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (rst_prev) begin
                pend = 1'b0; starve = 0;
                last_addr = '0; last_wdata = '0; last_we = 1'b0; last_whb = '0;
            end

            // registered outputs for this cycle
            exp_en   = pend && (cyc == t_gnt + 1);
            exp_busy = pend && (cyc >= t_gnt + 1) && (cyc <= t_gnt + 1 + int'(L));
            exp_iv   = pend && p_fetch && !p_killed && (cyc == t_gnt + 2 + int'(L));
            exp_dv   = pend && !p_fetch && (cyc == t_gnt + 2 + int'(L));
            check_eq("mem_en",   32'(mem_en),   32'(exp_en));
            check_eq("mem_addr", mem_addr,      last_addr);
            check_eq("mem_we",   32'(mem_we),   32'(last_we));
            check_eq("mem_whb",  32'(mem_whb),  32'(last_whb));
            if (exp_en && !p_fetch) check_eq("mem_wdata", mem_wdata, last_wdata);
            check_eq("busy",      32'(busy),      32'(exp_busy));
            check_eq("if_rvalid", 32'(if_rvalid), 32'(exp_iv));
            check_eq("d_rvalid",  32'(d_rvalid),  32'(exp_dv));
            if (exp_iv) check_eq("if_rdata", if_rdata, p_data);
            if (exp_dv) check_eq("d_rdata",  d_rdata,  p_data);
            if (pend && cyc == t_gnt + 2 + int'(L)) pend = 1'b0;

            // stimulus: 1 = both ports saturated, 2 = kill-heavy, 0 = random with resets
            if ((cyc >= 3 && cyc < 200) || (cyc >= 1400 && cyc < 1600)) mode = 1;
            else if (cyc >= 800 && cyc < 1000) mode = 2;
            else mode = 0;

            rst = (cyc < 3) || (mode == 0 && $urandom_range(79) == 0);
            if (!if_pend && (mode == 1 || $urandom_range(2) == 0)) begin
                if_pend = 1'b1;
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_pend && (mode == 1 || $urandom_range(2) == 0)) begin
                d_pend  = 1'b1;
                d_we    = 1'($urandom_range(1));
                d_addr  = $urandom();
                d_wdata = $urandom();
                d_whb   = 3'($urandom_range(7));
            end
            if_req  = if_pend;
            d_req   = d_pend;
            if_kill = (mode == 2) ? ($urandom_range(3) == 0) :
                      (mode == 0) ? ($urandom_range(11) == 0) : 1'b0;
            mem_rdata = (pend && cyc == t_gnt + 1 + int'(L)) ? mem_fn(p_addr) : $urandom();

            #1;
            if (pend && p_fetch && if_kill) p_killed = 1'b1;
            exp_ig = 1'b0;
            exp_dg = 1'b0;
            if (!rst && !pend) begin
                if (if_req && !if_kill && (!d_req || starve == int'(SL))) exp_ig = 1'b1;
                else if (d_req) exp_dg = 1'b1;
            end
            check_eq("if_gnt", 32'(if_gnt), 32'(exp_ig));
            check_eq("d_gnt",  32'(d_gnt),  32'(exp_dg));

            if (exp_ig) begin
                pend = 1'b1; t_gnt = cyc; p_fetch = 1'b1; p_killed = 1'b0; p_store = 1'b0;
                p_addr = if_addr; p_data = mem_fn(if_addr);
                last_addr = if_addr; last_we = 1'b0; last_whb = 3'b010;
                starve = 0;
            end
            if (exp_dg) begin
                pend = 1'b1; t_gnt = cyc; p_fetch = 1'b0; p_killed = 1'b0; p_store = d_we;
                p_addr = d_addr; p_data = d_we ? 32'd0 : mem_fn(d_addr);
                last_addr = d_addr; last_we = d_we; last_whb = d_whb; last_wdata = d_wdata;
                if (if_req) starve = (starve < int'(SL)) ? starve + 1 : int'(SL);
            end

            if (if_gnt) if_pend = 1'b0;
            if (d_gnt)  d_pend  = 1'b0;
            rst_prev = rst;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the instruction-fetch port (stage 1) and the data-access port (stage 4).
- Data accesses have priority; a starvation counter guarantees fetch progress.
- Only one access is outstanding at a time.
- A fetch in flight when the pipeline flushes on a branch mispredict has its response discarded.

Parameters:
MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15)
STARVE_LIMIT, 4, consecutive data grants made while if_req is high before fetch is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  32  fetch address
if_kill  in  1  pipeline flush (mispredict); cancels the fetch in flight or the one being requested
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  32  fetch data
d_req  in  1  data request; held with its fields until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address
d_wdata  in  32  store data
d_whb  in  3  width/sign code, passed through unchanged
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  load data valid, or store complete; one-cycle pulse
d_rdata  out  32  load data; 0 for stores
mem_en  out  1  memory access strobe, one-cycle pulse
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_whb  out  3  memory width code
mem_rdata  in  32  memory read data
busy  out  1  an access is in flight

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. busy = (state != IDLE).
- Grants are combinational and asserted only in IDLE. At most one of if_gnt and d_gnt is high in any cycle.
- Fetch is eligible when if_req && !if_kill.
- Arbitration in IDLE:
  - only one requester eligible -> that requester wins;
  - both eligible -> data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Grant in cycle T:
  - in T+1: mem_en=1; mem_addr, mem_we, mem_wdata and mem_whb hold values registered from the winner in T (for fetch: mem_we=0, mem_whb=3'b010);
  - state moves to BUSY_I or BUSY_D and lat_cnt starts at 1.
- lat_cnt counts up each cycle after T+1. mem_rdata is captured in cycle T+1+MEM_LATENCY.
- In T+2+MEM_LATENCY:
  - the registered x_rvalid pulses with registered x_rdata;
  - state returns to IDLE in that same cycle, so a new grant may occur in the cycle of the rvalid pulse.
- Minimum spacing between grants is MEM_LATENCY+2 cycles.
- mem_* outputs other than mem_en hold their last values between accesses. mem_en is 0 outside the issue cycle.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each d_gnt while if_req is high;
  - cleared on if_gnt;
  - unchanged otherwise.
- if_kill:
  - asserted at any time during BUSY_I, including the capture cycle -> that fetch's if_rvalid is suppressed (kill flag registered);
  - the FSM still waits for the full latency before returning to IDLE;
  - the kill flag is cleared on return to IDLE;
  - if_kill has no effect on data accesses.
- Stores: d_rvalid pulses at the same timing as loads, with d_rdata = 0.
- Reset, including mid-access:
  - state = IDLE; lat_cnt, starve_cnt and kill flag = 0;
  - if_rvalid, d_rvalid, mem_en, mem_we = 0; all data/address outputs = 0;
  - any in-flight response is dropped.
  - The first grant is possible in the cycle after rst deasserts.

Test Plan:
- Single fetch, MEM_LATENCY=2. if_req with if_addr=0x100 at cycle 0 -> if_gnt@0; mem_en@1 with mem_addr=0x100, mem_we=0; mem_rdata=0x00500093 @3 -> if_rvalid@4 with if_rdata=0x00500093; busy high cycles 1-3.
- Simultaneous requests at cycle 0, store d_addr=0x20, d_wdata=0xDEADBEEF -> d_gnt@0, if_gnt=0; mem_we=1 and mem_wdata=0xDEADBEEF @1; d_rvalid@4 with d_rdata=0; if_gnt@4.
- Starvation, STARVE_LIMIT=4: d_req and if_req held high continuously -> d_gnt four times; fifth grant goes to fetch; starve_cnt reads 0 afterward.
- Kill: fetch granted @0, if_kill pulsed @2 -> no if_rvalid @4; busy drops @4; a d_req pending since @1 gets d_gnt @4.
- Kill in IDLE: if_req and if_kill both high at cycle 0 with no d_req -> no grant and no mem_en @1.
- Reset mid-access: rst asserted @2 during BUSY_D -> @3 busy=0 and d_rvalid=0; no response ever appears for that access; new grant possible @4 after rst deasserts @3.
